// File: rtl/mcs_gpio_bank.sv
// mcs_gpio_bank: NUM_CH x WIDTH-bit GPIO channels on the MicroBlaze MCS IO bus.
// Each channel has byte-writable outputs (+0x0), synchronised inputs (+0x4)
// and, when GPIO_IRQ_EN is defined, change-detect interrupt enable (+0x8)
// and write-1-to-clear status (+0xC) registers driving one combined irq line.
// With GPIO_IRQ_EN undefined, +0x8/+0xC behave as unmapped and irq is 0.
module mcs_gpio_bank #(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_fpga,
  input  logic                      reset,
  input  logic                      io_addr_strobe,
  input  logic                      io_read_strobe,
  input  logic                      io_write_strobe,
  input  logic [7:0]                io_address,
  input  logic [3:0]                io_byte_enable,
  input  logic [31:0]               io_write_data,
  output logic [31:0]               io_read_data,
  output logic                      io_ready,
  input  logic [NUM_CH*WIDTH-1:0]   gpi,
  output logic [NUM_CH*WIDTH-1:0]   gpo,
  output logic                      irq
);

  // Bus decode: the write strobe wins if both strobes are seen together.
  logic              acc_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic [3:0]        ch_sel_s;
  logic [1:0]        off_sel_s;
  logic [31:0]       be_mask_s;
  logic [WIDTH-1:0]  wmask_s;
  logic [WIDTH-1:0]  wdata_s;
  logic [NUM_CH-1:0] ch_hit_s;
  logic              unused_s;

  assign acc_s     = io_addr_strobe & (io_read_strobe | io_write_strobe);
  assign wr_acc_s  = acc_s & io_write_strobe;
  assign rd_acc_s  = acc_s & io_read_strobe & ~io_write_strobe;
  assign ch_sel_s  = io_address[7:4];
  assign off_sel_s = io_address[3:2];
  assign be_mask_s = {{8{io_byte_enable[3]}}, {8{io_byte_enable[2]}},
                      {8{io_byte_enable[1]}}, {8{io_byte_enable[0]}}};
  assign wmask_s   = be_mask_s[WIDTH-1:0];
  assign wdata_s   = io_write_data[WIDTH-1:0];
  // Byte offset bits and lanes above WIDTH carry no meaning here.
  assign unused_s  = ^{io_address[1:0], io_write_data, be_mask_s};

  // One-hot channel hit; channel indices at or above NUM_CH never hit.
  always_comb begin
    ch_hit_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_hit_s[c] = (ch_sel_s == 4'(c));
    end
  end

  // Input synchroniser chains.
  logic [SYNC_STAGES-1:0][NUM_CH-1:0][WIDTH-1:0] sync_q;
  logic [NUM_CH-1:0][WIDTH-1:0] gpi_sync_s;
  assign gpi_sync_s = sync_q[SYNC_STAGES-1];

  // Shift the raw pins through SYNC_STAGES flops.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= gpi;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Output registers.
  logic [NUM_CH-1:0][WIDTH-1:0] gpo_q, gpo_d;
  logic                         wr_gpo_s;
  assign wr_gpo_s = wr_acc_s & (off_sel_s == 2'd0);
  assign gpo      = gpo_q;

  // GPO next state: merge enabled byte lanes of the addressed channel.
  always_comb begin
    gpo_d = gpo_q;
    for (int c = 0; c < NUM_CH; c++) begin
      gpo_d[c] = (gpo_q[c] & ~(wmask_s & {WIDTH{wr_gpo_s & ch_hit_s[c]}}))
               | (wdata_s & wmask_s & {WIDTH{wr_gpo_s & ch_hit_s[c]}});
    end
  end

`ifdef GPIO_IRQ_EN
  // Interrupt enable/status, change detection and arming after reset.
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [NUM_CH-1:0][WIDTH-1:0] en_q, en_d;
  logic [NUM_CH-1:0][WIDTH-1:0] stat_q, stat_d;
  logic [NUM_CH-1:0][WIDTH-1:0] prev_q;
  logic [2:0]                   arm_q, arm_d;
  logic                         armed_s;
  logic                         wr_en_s;
  logic                         wr_stat_s;

  assign armed_s   = (arm_q == ARM_DONE);
  assign wr_en_s   = wr_acc_s & (off_sel_s == 2'd2);
  assign wr_stat_s = wr_acc_s & (off_sel_s == 2'd3);
  assign arm_d     = armed_s ? arm_q : (arm_q + 3'd1);
  assign irq       = |(stat_q & en_q);

  // Enable writes and status W1C/set; a new change beats a same-cycle clear.
  always_comb begin
    en_d   = en_q;
    stat_d = stat_q;
    for (int c = 0; c < NUM_CH; c++) begin
      en_d[c]   = (en_q[c] & ~(wmask_s & {WIDTH{wr_en_s & ch_hit_s[c]}}))
                | (wdata_s & wmask_s & {WIDTH{wr_en_s & ch_hit_s[c]}});
      stat_d[c] = (stat_q[c] & ~(wdata_s & wmask_s & {WIDTH{wr_stat_s & ch_hit_s[c]}}))
                | ((gpi_sync_s[c] ^ prev_q[c]) & {WIDTH{armed_s}});
    end
  end

  // Interrupt state registers.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      en_q   <= '0;
      stat_q <= '0;
      prev_q <= '0;
      arm_q  <= 3'd0;
    end else begin
      en_q   <= en_d;
      stat_q <= stat_d;
      prev_q <= gpi_sync_s;
      arm_q  <= arm_d;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux: select the addressed channel, then the register by offset.
  logic [WIDTH-1:0] ch_gpo_s;
  logic [WIDTH-1:0] ch_gpi_s;
  logic [WIDTH-1:0] rd_val_s;
  logic [31:0]      rdata_d, rdata_q;
  logic             ready_q;
`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] ch_en_s;
  logic [WIDTH-1:0] ch_stat_s;
`endif

  // Gather addressed channel values and pick the register; 0 when not a read.
  always_comb begin
    ch_gpo_s = '0;
    ch_gpi_s = '0;
`ifdef GPIO_IRQ_EN
    ch_en_s   = '0;
    ch_stat_s = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      ch_gpo_s = ch_gpo_s | (gpo_q[c]      & {WIDTH{ch_hit_s[c]}});
      ch_gpi_s = ch_gpi_s | (gpi_sync_s[c] & {WIDTH{ch_hit_s[c]}});
`ifdef GPIO_IRQ_EN
      ch_en_s   = ch_en_s   | (en_q[c]   & {WIDTH{ch_hit_s[c]}});
      ch_stat_s = ch_stat_s | (stat_q[c] & {WIDTH{ch_hit_s[c]}});
`endif
    end
    case (off_sel_s)
      2'd0:    rd_val_s = ch_gpo_s;
      2'd1:    rd_val_s = ch_gpi_s;
`ifdef GPIO_IRQ_EN
      2'd2:    rd_val_s = ch_en_s;
      2'd3:    rd_val_s = ch_stat_s;
`endif
      default: rd_val_s = '0;
    endcase
    rdata_d = 32'h0000_0000;
    rdata_d[WIDTH-1:0] = rd_val_s & {WIDTH{rd_acc_s}};
  end

  // Output registers and bus completion pulse.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      gpo_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      gpo_q   <= gpo_d;
      ready_q <= acc_s;
      rdata_q <= rdata_d;
    end
  end

  assign io_ready     = ready_q;
  assign io_read_data = rdata_q;

endmodule

// File: tb/tb_mcs_gpio_bank.sv
// Directed bench for mcs_gpio_bank (NUM_CH=2, WIDTH=32, SYNC_STAGES=2).
// Expectations for the interrupt registers follow whether GPIO_IRQ_EN is set.
module tb_mcs_gpio_bank;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk_fpga = 1'b0;
  logic        reset;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [7:0]  io_address;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;
  logic [63:0] gpi;
  logic [63:0] gpo;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  mcs_gpio_bank #(.NUM_CH(2), .WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk_fpga        (clk_fpga),
    .reset           (reset),
    .io_addr_strobe  (io_addr_strobe),
    .io_read_strobe  (io_read_strobe),
    .io_write_strobe (io_write_strobe),
    .io_address      (io_address),
    .io_byte_enable  (io_byte_enable),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .io_ready        (io_ready),
    .gpi             (gpi),
    .gpo             (gpo),
    .irq             (irq)
  );

  always #5 clk_fpga = ~clk_fpga;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
  endtask

  // Read strobe in one cycle; check the completion one cycle later.
  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk_fpga);
    io_address = a; io_addr_strobe = 1'b1; io_read_strobe = 1'b1;
    @(posedge clk_fpga); #1;
    idle_bus();
    chk({tag, "_rdy"}, io_ready, 1);
    chk(tag, io_read_data, exp);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, input string tag);
    @(negedge clk_fpga);
    io_address = a; io_write_data = d; io_byte_enable = be;
    io_addr_strobe = 1'b1; io_write_strobe = 1'b1;
    @(posedge clk_fpga); #1;
    idle_bus();
    chk({tag, "_rdy"}, io_ready, 1);
  endtask

  initial begin
    reset = 1'b1; idle_bus();
    io_address = 8'h00; io_byte_enable = 4'h0; io_write_data = 32'h0; gpi = 64'h0;
    repeat (3) @(posedge clk_fpga);
    #1;
    chk("rst_gpo", gpo, 64'h0);
    chk("rst_rdy", io_ready, 0);
    chk("rst_rdata", io_read_data, 32'h0);
    chk("rst_irq", irq, 0);
    @(negedge clk_fpga); reset = 1'b0;

    // All registers of both channels read 0 after reset.
    for (int r = 0; r < 8; r++) begin
      do_read(8'((r / 4) * 16 + (r % 4) * 4), 32'h0, $sformatf("rst_reg%0d", r));
    end
    @(posedge clk_fpga); #1;
    chk("rdy_drops", io_ready, 0);
    chk("rdata_drops", io_read_data, 32'h0);
    chk("irq_idle", irq, 0);

    // Byte-lane writes and readback.
    do_write(8'h10, 32'hA5A5_A5A5, 4'b0101, "wr_ch1");
    chk("gpo_ch1_now", gpo[63:32], 64'h00A5_00A5);
    do_write(8'h00, 32'h5A5A_5A5A, 4'b1111, "wr_ch0");
    chk("gpo_ch1", gpo[63:32], 64'h00A5_00A5);
    chk("gpo_ch0", gpo[31:0], 64'h5A5A_5A5A);
    do_read(8'h10, 32'h00A5_00A5, "rb_ch1");
    do_read(8'h00, 32'h5A5A_5A5A, "rb_ch0");
    do_write(8'h04, 32'hFFFF_FFFF, 4'b1111, "wr_gpi");
    do_read(8'h04, 32'h0, "gpi_ro");
    do_write(8'h10, 32'h1234_5678, 4'b1010, "wr_ch1_b");
    chk("gpo_ch1_b", gpo[63:32], 64'h1200_5600 | 64'h00A5_00A5);

    // Both strobes together: write takes effect, read data is 0.
    @(negedge clk_fpga);
    io_address = 8'h00; io_write_data = 32'h1234_5678; io_byte_enable = 4'hF;
    io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_write_strobe = 1'b1;
    @(posedge clk_fpga); #1;
    idle_bus();
    chk("rw_rdy", io_ready, 1);
    chk("rw_rdata", io_read_data, 32'h0);
    chk("rw_gpo", gpo[31:0], 64'h1234_5678);

    // Change detect on gpi[0] with enable set.
    do_write(8'h08, 32'h0000_0001, 4'b1111, "wr_en");
    do_read(8'h08, IRQ_ON ? 32'h1 : 32'h0, "rb_en");
    @(negedge clk_fpga); gpi[0] = 1'b1;
    @(posedge clk_fpga); #1;
    @(posedge clk_fpga); #1;
    chk("irq_before_set", irq, 0);
    do_read(8'h04, 32'h1, "gpi_bit0");
    chk("irq_set", irq, IRQ_ON ? 1 : 0);
    do_read(8'h0C, IRQ_ON ? 32'h1 : 32'h0, "stat_bit0");
    do_write(8'h0C, 32'h0000_0001, 4'b1111, "w1c_bit0");
    chk("irq_cleared", irq, 0);
    do_read(8'h0C, 32'h0, "stat_cleared");

    // Reset mid-write with inputs high: nothing is written, nothing spurious.
    @(negedge clk_fpga);
    gpi = {64{1'b1}}; reset = 1'b1;
    io_address = 8'h00; io_write_data = 32'hDEAD_BEEF; io_byte_enable = 4'hF;
    io_addr_strobe = 1'b1; io_write_strobe = 1'b1;
    @(posedge clk_fpga); #1;
    idle_bus();
    chk("midrst_gpo", gpo, 64'h0);
    chk("midrst_rdy", io_ready, 0);
    @(posedge clk_fpga);
    @(negedge clk_fpga); reset = 1'b0;
    repeat (6) @(posedge clk_fpga);
    do_read(8'h0C, 32'h0, "arm_stat0");
    do_read(8'h1C, 32'h0, "arm_stat1");
    do_read(8'h14, 32'hFFFF_FFFF, "gpi_ch1_ones");
    @(negedge clk_fpga); gpi[5] = 1'b0;
    repeat (3) @(posedge clk_fpga);
    do_read(8'h0C, IRQ_ON ? 32'h0000_0020 : 32'h0, "stat_bit5");
    chk("irq_masked", irq, 0);

    // Status set and W1C of bit 3 in the same cycle: set wins.
    do_write(8'h0C, 32'hFFFF_FFFF, 4'b1111, "w1c_all");
    do_read(8'h0C, 32'h0, "stat_all_clr");
    @(negedge clk_fpga); gpi[3] = 1'b0;
    @(posedge clk_fpga);
    @(posedge clk_fpga);
    do_write(8'h0C, 32'h0000_0008, 4'b1111, "w1c_race");
    do_read(8'h0C, IRQ_ON ? 32'h0000_0008 : 32'h0, "stat_set_wins");

    // Back-to-back write then read of an unmapped channel.
    @(negedge clk_fpga);
    io_address = 8'h20; io_write_data = 32'hFFFF_FFFF; io_byte_enable = 4'hF;
    io_addr_strobe = 1'b1; io_write_strobe = 1'b1;
    @(negedge clk_fpga);
    io_write_strobe = 1'b0; io_read_strobe = 1'b1;
    #1;
    chk("b2b_rdy1", io_ready, 1);
    chk("b2b_gpo", gpo, 64'h0);
    @(negedge clk_fpga);
    idle_bus();
    #1;
    chk("b2b_rdy2", io_ready, 1);
    chk("b2b_rdata", io_read_data, 32'h0);
    @(negedge clk_fpga);
    chk("b2b_rdy_end", io_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mcs_gpio_bank.md
# mcs_gpio_bank

Parametrised multi-channel GPIO peripheral on the MicroBlaze MCS IO bus. It succeeds the fixed single 32-bit GPI/GPO pair on the soft-core wrapper with NUM_CH channels of WIDTH bits each. Each channel provides byte-writable outputs, synchronised inputs and per-bit change-detect interrupts. It sits beside the MCS instance in the top level and drives one combined interrupt line back to the core.

## Interface
- NUM_CH, 2: number of channels, 1..8
- WIDTH, 32: bits per channel, 1..32
- SYNC_STAGES, 2: input synchroniser depth, 2..4
- clk_fpga  in  1  system clock; all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- io_addr_strobe  in  1  MCS address strobe; qualifies io_address
- io_read_strobe  in  1  single-cycle read request
- io_write_strobe  in  1  single-cycle write request
- io_address  in  8  byte address; bits [1:0] ignored
- io_byte_enable  in  4  write byte lanes
- io_write_data  in  32  write data
- io_read_data  out  32  read data; valid only while io_ready=1, else 0
- io_ready  out  1  one-cycle completion pulse
- gpi  in  NUM_CH*WIDTH  asynchronous inputs; channel n at [n*WIDTH +: WIDTH]
- gpo  out  NUM_CH*WIDTH  registered outputs, same packing
- irq  out  1  level interrupt: OR over all channels of (status & enable)

## Operation
- Register map: channel n base = n*0x10.
  - +0x0 GPO (R/W)
  - +0x4 GPI (RO; synchronised value)
  - +0x8 IRQ_EN (R/W)
  - +0xC IRQ_STAT (RO; write-1-to-clear)
- Bits [31:WIDTH] read 0 and ignore writes.
- Writes honour io_byte_enable per lane. Lanes entirely above WIDTH are no-ops.
- A transaction is accepted on a cycle where io_read_strobe or io_write_strobe is high together with io_addr_strobe.
  - Read and write strobes never assert together. If they do, the write wins and io_read_data returns 0.
- Unmapped address: channel index >= NUM_CH, or an offset not listed above.
  - Writes are ignored, reads return 0, and io_ready still pulses.
- Each gpi bit passes through a SYNC_STAGES flop chain. A prev register holds the previous synchronised value.
- Change detect: a bit differing between sync and prev sets the IRQ_STAT bit. This happens regardless of IRQ_EN; the enable only gates irq.
- Arming: after reset deassertion, a counter suppresses status setting for SYNC_STAGES+1 cycles. This prevents a spurious change when the inputs are already high at reset release.
- Same cycle set and W1C clear of one status bit: set wins, and the bit stays 1.
- Writes to GPI are ignored. Writes to IRQ_STAT with 0 bits leave those bits unchanged.

## Timing
- Reset values: gpo=0, io_ready=0, io_read_data=0, irq=0. All GPO/IRQ_EN/IRQ_STAT registers, sync chains, prev and the arming counter are 0.
- Latency: strobe in cycle T gives io_ready=1 in cycle T+1, exactly one cycle.
  - For reads, io_read_data holds the value in T+1 and returns to 0 in T+2.
  - A new strobe in cycle T+1 is legal (back-to-back). It completes in T+2.
- Write effect: the register and gpo update at the T+1 edge, so gpo shows new data in T+1. A read issued in T+1 returns the written value.
- GPI latency: a pin change appears in the GPI register SYNC_STAGES cycles later. IRQ_STAT sets one cycle after that, and irq follows combinationally from registered status/enable (same cycle).
- Reset asserted mid-transaction: the pending io_ready is dropped and no write takes effect after the reset edge.

## Configuration
- GPIO_IRQ_EN defined: IRQ_EN/IRQ_STAT registers, prev registers, arming counter and irq generation are present as described.
- Undefined: none of that logic exists. Offsets +0x8/+0xC behave as unmapped (read 0, writes ignored, io_ready still pulses), and irq is tied 0.
- Register map and GPO/GPI behaviour are otherwise identical.

## Test plan
- Reset, then read all registers of both channels (NUM_CH=2, WIDTH=32) -> every read returns 0x00000000, io_ready one cycle after each strobe, irq=0.
- Write 0xA5A5A5A5 to 0x10 with byte_enable=4'b0101, then write 0x5A5A5A5A to 0x00 with all enables -> gpo[63:32]=0x00A500A5, gpo[31:0]=0x5A5A5A5A; readback matches.
- Set IRQ_EN ch0 = 0x1, raise gpi[0] -> GPI@0x04 reads 0x1 after 2 cycles; IRQ_STAT@0x0C bit0=1 and irq=1 the next cycle; write 0x1 to 0x0C -> irq=0.
- Hold gpi=all-ones through reset release -> IRQ_STAT stays 0; then drop gpi[5] -> IRQ_STAT bit5=1.
- Toggle gpi[3] so the status set lands in the same cycle as a W1C write of bit3 -> bit3 reads 1 afterwards.
- Back-to-back write then read of 0x20 (unmapped for NUM_CH=2) -> two io_ready pulses in consecutive cycles, read data 0.
